// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: walks input neurons and weights for each output neuron of one MLP layer,
// pulsing accumulator clear on the first product and issuing one write per output neuron.
module mlp_layer_sequencer #(
  parameter int NA_W  = 12,
  parameter int WA_W  = 16,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_num_in,
  input  logic [CNT_W-1:0] i_num_out,
  input  logic [NA_W-1:0]  i_in_base,
  input  logic [NA_W-1:0]  i_out_base,
  input  logic [WA_W-1:0]  i_w_base,
  output logic             o_busy,
  output logic             o_done_1,
  output logic [NA_W-1:0]  o_neuron_addr_1,
  output logic [WA_W-1:0]  o_weight_addr_1,
  output logic             o_reset_mult_acc_1,
  output logic [NA_W-1:0]  o_out_neuron_addr_1,
  output logic             o_write_neuron_1
);
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;
  state_t           r_state;
  logic             r_run_q, r_arm;
  logic [CNT_W-1:0] r_num_in, r_num_out, r_i, r_j;
  logic [NA_W-1:0]  r_in_base, r_out_base;
  logic             w_start, w_last_i, w_last_j;
  // r_arm blocks a start after reset until run has been seen low once
  assign w_start  = i_run & ~r_run_q & r_arm;
  assign w_last_i = r_i == r_num_in - CNT_W'(1);
  assign w_last_j = r_j == r_num_out - CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_IDLE;
      r_run_q             <= 1'b0;
      r_arm               <= 1'b0;
      r_num_in            <= '0;
      r_num_out           <= '0;
      r_in_base           <= '0;
      r_out_base          <= '0;
      r_i                 <= '0;
      r_j                 <= '0;
      o_busy              <= 1'b0;
      o_done_1            <= 1'b0;
      o_neuron_addr_1     <= '0;
      o_weight_addr_1     <= '0;
      o_reset_mult_acc_1  <= 1'b0;
      o_out_neuron_addr_1 <= '0;
      o_write_neuron_1    <= 1'b0;
    end else begin
      r_run_q <= i_run;
      if (!i_run) begin
        r_arm               <= 1'b1;
        r_state             <= S_IDLE;
        o_busy              <= 1'b0;
        o_done_1            <= 1'b0;
        o_neuron_addr_1     <= '0;
        o_weight_addr_1     <= '0;
        o_reset_mult_acc_1  <= 1'b0;
        o_out_neuron_addr_1 <= '0;
        o_write_neuron_1    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_num_in   <= i_num_in;
            r_num_out  <= i_num_out;
            r_in_base  <= i_in_base;
            r_out_base <= i_out_base;
            r_i        <= '0;
            r_j        <= '0;
            if (i_num_in == '0 || i_num_out == '0) begin
              r_state  <= S_DONE;
              o_done_1 <= 1'b1;
            end else begin
              r_state            <= S_MAC;
              o_busy             <= 1'b1;
              o_neuron_addr_1    <= i_in_base;
              o_weight_addr_1    <= i_w_base;
              o_reset_mult_acc_1 <= 1'b1;
            end
          end
          S_MAC: begin
            o_reset_mult_acc_1 <= 1'b0;
            if (w_last_i) begin
              r_state             <= S_WRITE;
              o_write_neuron_1    <= 1'b1;
              o_out_neuron_addr_1 <= r_out_base + NA_W'(r_j);
            end else begin
              r_i             <= r_i + CNT_W'(1);
              o_neuron_addr_1 <= o_neuron_addr_1 + NA_W'(1);
              o_weight_addr_1 <= o_weight_addr_1 + WA_W'(1);
            end
          end
          S_WRITE: begin
            o_write_neuron_1 <= 1'b0;
            r_i              <= '0;
            if (w_last_j) begin
              r_state  <= S_DONE;
              o_busy   <= 1'b0;
              o_done_1 <= 1'b1;
            end else begin
              r_state            <= S_MAC;
              r_j                <= r_j + CNT_W'(1);
              o_neuron_addr_1    <= r_in_base;
              o_weight_addr_1    <= o_weight_addr_1 + WA_W'(1);
              o_reset_mult_acc_1 <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: directed vectors with hand-computed expected outputs
// for mlp_layer_sequencer, including abort, wrap, async reset and hold cases.
module tb_mlp_layer_sequencer;
  typedef struct packed {
    logic        busy, done, wr, rst;
    logic [11:0] n;
    logic [15:0] w;
    logic [11:0] o;
  } out_t;
  typedef struct packed {
    logic run;
    out_t e;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [11:0] num_in = '0, num_out = '0, in_base = '0, out_base = '0;
  logic [15:0] w_base = '0;
  logic        busy, done_1, rst_acc, wr;
  logic [11:0] n_addr, o_addr;
  logic [15:0] w_addr;
  int          n_chk = 0, n_err = 0;
  vec_t        tbl [11];
  mlp_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_num_in(num_in), .i_num_out(num_out),
    .i_in_base(in_base), .i_out_base(out_base), .i_w_base(w_base),
    .o_busy(busy), .o_done_1(done_1), .o_neuron_addr_1(n_addr), .o_weight_addr_1(w_addr),
    .o_reset_mult_acc_1(rst_acc), .o_out_neuron_addr_1(o_addr), .o_write_neuron_1(wr)
  );
  always #5 clk = ~clk;
  function automatic out_t mk(input logic b, d, r, a, input logic [11:0] n, input logic [15:0] w,
                              input logic [11:0] o);
    mk = {b, d, r, a, n, w, o};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = {busy, done_1, wr, rst_acc, n_addr, w_addr, o_addr};
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b wr=%b rst=%b n=%h w=%h o=%h, want busy=%b done=%b wr=%b rst=%b n=%h w=%h o=%h",
               nm, a.busy, a.done, a.wr, a.rst, a.n, a.w, a.o, e.busy, e.done, e.wr, e.rst, e.n, e.w, e.o);
    end
  endtask
  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic cfg1();
    num_in = 12'd3; num_out = 12'd2; in_base = 12'h010; out_base = 12'h100; w_base = 16'h0200;
  endtask
  initial begin
    int bad;
    tbl[0]  = {1'b1, mk(1, 0, 0, 1, 12'h010, 16'h0200, 12'h000)};
    tbl[1]  = {1'b1, mk(1, 0, 0, 0, 12'h011, 16'h0201, 12'h000)};
    tbl[2]  = {1'b1, mk(1, 0, 0, 0, 12'h012, 16'h0202, 12'h000)};
    tbl[3]  = {1'b1, mk(1, 0, 1, 0, 12'h012, 16'h0202, 12'h100)};
    tbl[4]  = {1'b1, mk(1, 0, 0, 1, 12'h010, 16'h0203, 12'h100)};
    tbl[5]  = {1'b1, mk(1, 0, 0, 0, 12'h011, 16'h0204, 12'h100)};
    tbl[6]  = {1'b1, mk(1, 0, 0, 0, 12'h012, 16'h0205, 12'h100)};
    tbl[7]  = {1'b1, mk(1, 0, 1, 0, 12'h012, 16'h0205, 12'h101)};
    tbl[8]  = {1'b1, mk(0, 1, 0, 0, 12'h012, 16'h0205, 12'h101)};
    tbl[9]  = {1'b1, mk(0, 1, 0, 0, 12'h012, 16'h0205, 12'h101)};
    tbl[10] = {1'b0, mk(0, 0, 0, 0, 12'h000, 16'h0000, 12'h000)};
    #2;
    chk("reset", mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cfg1();
    for (int k = 0; k < 11; k++) begin
      run = tbl[k].run;
      step();
      chk($sformatf("basic[%0d]", k), tbl[k].e);
    end
    // degenerate: zero input count goes straight to done
    num_in = 12'd0; num_out = 12'd5;
    run = 1'b1; step();
    chk("degen_done", mk(0, 1, 0, 0, 0, 0, 0));
    run = 1'b0; step();
    chk("degen_idle", mk(0, 0, 0, 0, 0, 0, 0));
    // abort in second MAC, then restart
    cfg1();
    run = 1'b1; step();
    chk("abort_mac0", mk(1, 0, 0, 1, 12'h010, 16'h0200, 12'h000));
    step();
    chk("abort_mac1", mk(1, 0, 0, 0, 12'h011, 16'h0201, 12'h000));
    run = 1'b0; step();
    chk("abort_idle", mk(0, 0, 0, 0, 0, 0, 0));
    run = 1'b1; step();
    chk("abort_restart", mk(1, 0, 0, 1, 12'h010, 16'h0200, 12'h000));
    run = 1'b0; step();
    // weight address wrap
    num_in = 12'd4; num_out = 12'd1; in_base = 12'h000; out_base = 12'h020; w_base = 16'hFFFE;
    run = 1'b1; step();
    chk("wrap0", mk(1, 0, 0, 1, 12'h000, 16'hFFFE, 12'h000));
    step(); chk("wrap1", mk(1, 0, 0, 0, 12'h001, 16'hFFFF, 12'h000));
    step(); chk("wrap2", mk(1, 0, 0, 0, 12'h002, 16'h0000, 12'h000));
    step(); chk("wrap3", mk(1, 0, 0, 0, 12'h003, 16'h0001, 12'h000));
    step(); chk("wrap_wr", mk(1, 0, 1, 0, 12'h003, 16'h0001, 12'h020));
    step(); chk("wrap_done", mk(0, 1, 0, 0, 12'h003, 16'h0001, 12'h020));
    run = 1'b0; step();
    // config changes after start are ignored; done then holds with no writes
    cfg1();
    run = 1'b1; step();
    num_in = 12'd1; num_out = 12'd1; in_base = 12'h7FF; out_base = 12'h7FF; w_base = 16'h1234;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (done_1) bad++;
    end
    chk_int("hold_early_done", bad, 0);
    step();
    chk("hold_done", mk(0, 1, 0, 0, 12'h012, 16'h0205, 12'h101));
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!done_1 || wr || busy) bad++;
    end
    chk_int("hold_20", bad, 0);
    run = 1'b0; step();
    // async reset mid-write, then no start while run stays high
    cfg1();
    run = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("areset_pre", mk(1, 0, 1, 0, 12'h012, 16'h0202, 12'h100));
    #2 rst_n = 1'b0;
    #1 chk("areset_now", mk(0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (busy || done_1 || wr) bad++;
    end
    chk_int("areset_nostart", bad, 0);
    run = 1'b0; step();
    run = 1'b1; step();
    chk("areset_restart", mk(1, 0, 0, 1, 12'h010, 16'h0200, 12'h000));
    run = 1'b0; step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
